// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: pipeline controller state encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running cycle and stall counters for the pipeline controller; both wrap.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             cyc_inc,
    input  logic             stall_inc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, cyc_inc};
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_inc};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller. Define PIPE_PERF_CNT_EN to build the
// cycle/stall performance counters; otherwise the counter ports read 0.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int BRANCH_STAGE = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic                  dmem_req,
    input  logic                  hazard,
    input  logic                  branch_taken,
    input  logic                  halt_req,
    output logic [NUM_STAGES-2:0] stage_en,
    output logic [NUM_STAGES-2:0] stage_flush,
    output logic                  pc_en,
    output logic                  pc_sel,
    output logic                  imemREN,
    output logic                  halt,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int              DCW        = $clog2(NUM_STAGES);
    localparam logic [DCW-1:0]  DRAIN_LOAD = DCW'(NUM_STAGES - 2);

    pipe_state_t    state_q, state_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           halt_q, halt_d;
    logic           dstall, istall;

    always_comb begin
        imemREN     = (state_q == RUN);
        dstall      = dmem_req & ~dhit;
        istall      = imemREN & ~ihit;
        stage_en    = '1;
        stage_flush = '0;
        pc_en       = 1'b1;
        pc_sel      = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        halt_d      = halt_q;

        if (state_q == HALTED) begin
            stage_en = '0;
            pc_en    = 1'b0;
        end else begin
            if (dstall) begin
                stage_en = '0;
                pc_en    = 1'b0;
            end else if (branch_taken) begin
                for (int i = 0; i < NUM_STAGES - 1; i++)
                    stage_flush[i] = (i < BRANCH_STAGE);
                pc_sel = 1'b1;
            end else if (hazard) begin
                stage_en[0]    = 1'b0;
                stage_flush[1] = 1'b1;
                pc_en          = 1'b0;
            end else if (istall) begin
                stage_flush[0] = 1'b1;
                pc_en          = 1'b0;
            end

            // While draining nothing new enters; a taken branch still redirects the PC.
            if (state_q == DRAIN) begin
                stage_flush[0] = 1'b1;
                if (dstall || !branch_taken)
                    pc_en = 1'b0;
            end

            if (state_q == RUN) begin
                if (halt_req && !dstall && !branch_taken) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end else if (!dstall) begin
                // The counter holds the drain cycles left, including the current one.
                if (branch_taken) begin
                    state_d = RUN;
                    drain_d = '0;
                end else if (drain_q <= DCW'(1)) begin
                    state_d = HALTED;
                    drain_d = '0;
                    halt_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            drain_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halt_q  <= halt_d;
        end
    end

    assign halt = halt_q;

`ifdef PIPE_PERF_CNT_EN
    logic cyc_inc, stall_inc;
    assign cyc_inc   = (state_q != HALTED);
    assign stall_inc = dstall | hazard | istall;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
        .CLK       (CLK),
        .nRST      (nRST),
        .cyc_inc   (cyc_inc),
        .stall_inc (stall_inc),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed halt/drain
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int NS    = 5;
    localparam int BS    = 2;
    localparam int CNT_W = 32;
    localparam logic [NS-2:0] ALL1 = '1;

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    logic ihit = 1'b0, dhit = 1'b0, dmem_req = 1'b0, hazard = 1'b0;
    logic branch_taken = 1'b0, halt_req = 1'b0;
    logic [NS-2:0] stage_en, stage_flush;
    logic pc_en, pc_sel, imemREN, halt;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt;

    pipeline_ctrl #(.NUM_STAGES(NS), .BRANCH_STAGE(BS), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .dmem_req     (dmem_req),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .halt_req     (halt_req),
        .stage_en     (stage_en),
        .stage_flush  (stage_flush),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .imemREN      (imemREN),
        .halt         (halt),
        .cycle_cnt    (cycle_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: whether we are halting, how many drain cycles remain.
    bit          m_halted, m_draining;
    int          m_left;
    bit          m_halt;
    logic [CNT_W-1:0] m_cyc, m_stall;

    // Outputs sampled during the most recent step.
    logic [NS-2:0] s_en, s_flush;
    logic s_pc, s_sel, s_imem, s_halt;
    logic [CNT_W-1:0] s_cyc, s_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_exp(input logic [CNT_W-1:0] v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_halted = 0; m_draining = 0; m_left = 0; m_halt = 0;
        m_cyc = '0; m_stall = '0;
    endtask

    task automatic check_model(input logic ih, dh, dr, hz, br);
        logic [NS-2:0] e_en, e_fl;
        logic e_pc, e_sel, e_im, dst, ist;
        e_im = !m_halted && !m_draining;
        dst  = dr && !dh;
        ist  = e_im && !ih;
        e_en = ALL1; e_fl = '0; e_pc = 1'b1; e_sel = 1'b0;
        if (m_halted) begin
            e_en = '0; e_pc = 1'b0;
        end else if (dst) begin
            e_en = '0; e_pc = 1'b0;
        end else if (br) begin
            e_fl = NS'((1 << BS) - 1); e_sel = 1'b1;
        end else if (hz) begin
            e_en = ALL1 & ~NS'(1); e_fl = NS'(2); e_pc = 1'b0;
        end else if (ist) begin
            e_fl = NS'(1); e_pc = 1'b0;
        end
        if (m_draining) begin
            e_fl[0] = 1'b1;
            if (dst || !br) e_pc = 1'b0;
        end
        chk("model_stage_en", stage_en, e_en);
        chk("model_stage_flush", stage_flush, e_fl);
        chk("model_pc_en", pc_en, e_pc);
        chk("model_pc_sel", pc_sel, e_sel);
        chk("model_imemREN", imemREN, e_im);
        chk("model_halt", halt, m_halt);
        chk("model_cycle_cnt", cycle_cnt, cnt_exp(m_cyc));
        chk("model_stall_cnt", stall_cnt, cnt_exp(m_stall));
    endtask

    task automatic model_update(input logic ih, dh, dr, hz, br, hr);
        bit dst, ist;
        dst = dr && !dh;
        ist = !m_halted && !m_draining && !ih;
        if (dst || hz || ist) m_stall++;
        if (!m_halted) m_cyc++;
        if (m_halted) return;
        if (!m_draining) begin
            if (hr && !dst && !br) begin
                m_draining = 1; m_left = NS - 2;
            end
        end else if (!dst) begin
            if (br) m_draining = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_draining = 0; m_halted = 1; m_halt = 1;
                end
            end
        end
    endtask

    task automatic step(input logic ih, dh, dr, hz, br, hr);
        @(negedge CLK);
        ihit = ih; dhit = dh; dmem_req = dr; hazard = hz; branch_taken = br; halt_req = hr;
        #1;
        s_en = stage_en; s_flush = stage_flush; s_pc = pc_en; s_sel = pc_sel;
        s_imem = imemREN; s_halt = halt; s_cyc = cycle_cnt; s_stall = stall_cnt;
        check_model(ih, dh, dr, hz, br);
        @(posedge CLK);
        model_update(ih, dh, dr, hz, br, hr);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        ihit = 1'b1; dhit = 1'b1; dmem_req = 1'b0; hazard = 1'b0;
        branch_taken = 1'b0; halt_req = 1'b0;
        #1;
        chk("reset_halt", halt, 1'b0);
        chk("reset_cycle_cnt", cycle_cnt, '0);
        chk("reset_stall_cnt", stall_cnt, '0);
        chk("reset_imemREN", imemREN, 1'b1);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    typedef struct {
        logic ih, dh, dr, hz, br;
        logic [NS-2:0] en, fl;
        logic pc, sel, im;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 1, 0, 0, 0, 4'b1111, 4'b0000, 1, 0, 1}; // normal advance
        tbl[1] = '{1, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1}; // data stall
        tbl[2] = '{1, 0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 1}; // data stall beats branch
        tbl[3] = '{1, 1, 0, 1, 1, 4'b1111, 4'b0011, 1, 1, 1}; // branch beats hazard
        tbl[4] = '{1, 1, 0, 1, 0, 4'b1110, 4'b0010, 0, 0, 1}; // load-use hazard
        tbl[5] = '{0, 1, 0, 0, 0, 4'b1111, 4'b0001, 0, 0, 1}; // fetch stall
        tbl[6] = '{0, 1, 0, 1, 0, 4'b1110, 4'b0010, 0, 0, 1}; // hazard beats fetch stall
        tbl[7] = '{1, 1, 1, 0, 0, 4'b1111, 4'b0000, 1, 0, 1}; // memory op that hits
        tbl[8] = '{0, 1, 0, 0, 1, 4'b1111, 4'b0011, 1, 1, 1}; // branch beats fetch stall

        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].ih, tbl[i].dh, tbl[i].dr, tbl[i].hz, tbl[i].br, 1'b0);
            chk($sformatf("vec%0d_stage_en", i), s_en, tbl[i].en);
            chk($sformatf("vec%0d_stage_flush", i), s_flush, tbl[i].fl);
            chk($sformatf("vec%0d_pc_en", i), s_pc, tbl[i].pc);
            chk($sformatf("vec%0d_pc_sel", i), s_sel, tbl[i].sel);
            chk($sformatf("vec%0d_imemREN", i), s_imem, tbl[i].im);
        end

        // Three data-stall cycles, then the access completes.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0, 0);
            chk("dstall_stage_en", s_en, 4'b0000);
            chk("dstall_pc_en", s_pc, 1'b0);
        end
        step(1, 1, 1, 0, 0, 0);
        chk("dstall_release_stage_en", s_en, 4'b1111);
        chk("dstall_stall_cnt", s_stall, cnt_exp(32'd3));

        // Halt with instruction fetch always hitting.
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        chk("halt_req_cycle_imemREN", s_imem, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0);
            chk("drain_imemREN", s_imem, 1'b0);
            chk("drain_halt", s_halt, 1'b0);
        end
        step(1, 1, 0, 0, 0, 0);
        chk("halted_halt", s_halt, 1'b1);
        chk("halted_stage_en", s_en, 4'b0000);
        chk("halted_pc_en", s_pc, 1'b0);
        chk("halted_cycle_cnt", s_cyc, cnt_exp(32'd4));
        step(1, 1, 0, 0, 0, 0);
        chk("halted_cycle_cnt_frozen", s_cyc, cnt_exp(32'd4));
        // Reset from HALTED: checked immediately inside do_reset.
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        chk("post_halt_reset_imemREN", s_imem, 1'b1);
        chk("post_halt_reset_halt", s_halt, 1'b0);

        // Wrong-path halt cancelled by a branch in the second drain cycle.
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("cancel_pc_sel", s_sel, 1'b1);
        chk("cancel_pc_en", s_pc, 1'b1);
        chk("cancel_stage_flush", s_flush, 4'b0011);
        step(1, 1, 0, 0, 0, 0);
        chk("cancel_imemREN", s_imem, 1'b1);
        chk("cancel_halt", s_halt, 1'b0);

        // Drain stretched by two data-stall cycles.
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, (i == 1 || i == 2) ? 1'b0 : 1'b1, 1, 0, 0, 0);
            chk("long_drain_imemREN", s_imem, 1'b0);
            chk("long_drain_halt", s_halt, 1'b0);
        end
        step(1, 1, 0, 0, 0, 0);
        chk("long_drain_halted", s_halt, 1'b1);

        // Reset asserted mid-drain.
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        chk("mid_drain_reset_imemREN", s_imem, 1'b1);

        // Randomized traffic in short segments, each started from reset.
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 60,
                     $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
